// File: rtl/nios_dbg_ocimem_sequencer_pkg.sv
// Shared types and jdo field positions for the OCI RAM sequencer.
package nios_dbg_pkg;

    localparam int unsigned JDO_W        = 38;
    localparam int unsigned JDO_ADDR_LSB = 17;
    localparam int unsigned JDO_DATA_LSB = 3;
    localparam int unsigned JDO_RDEN     = 35;
    localparam int unsigned CNT_W        = 4;

    typedef enum logic [2:0] {
        IDLE,
        J_RD,
        J_RCAP,
        J_WR,
        C_RD,
        C_RCAP,
        C_WR
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_RD,
        CMD_WR
    } cmd_t;

    // True while a JTAG access owns the RAM port.
    function automatic logic is_jtag_state(state_t s);
        return (s == J_RD) || (s == J_RCAP) || (s == J_WR);
    endfunction

endpackage

// File: rtl/nios_dbg_ocimem_sequencer_if.sv
// CPU debug-mode access port to the OCI RAM sequencer.
interface nios_dbg_ocimem_sequencer_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 32
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata
    );
endinterface

// File: rtl/nios_dbg_ocimem_sequencer_arb.sv
// JTAG-over-CPU priority arbiter with a starvation escape for the CPU.
module nios_dbg_arb
    import nios_dbg_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arb_en,
    input  logic jtag_req,
    input  logic cpu_req,
    output logic grant_jtag,
    output logic grant_cpu
);

    logic [CNT_W-1:0] starve_cnt;
    logic             cpu_due;

    // Grant decision; the CPU wins only when JTAG is idle or the CPU has waited long enough.
    always_comb begin
        cpu_due    = (starve_cnt == CNT_W'(STARVE_LIMIT));
        grant_cpu  = arb_en & cpu_req & (~jtag_req | cpu_due);
        grant_jtag = arb_en & jtag_req & ~grant_cpu;
    end

    // Count JTAG grants that overtake a waiting CPU request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!cpu_req || grant_cpu) begin
            starve_cnt <= '0;
        end else if (grant_jtag && !cpu_due) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nios_dbg_ocimem_sequencer.sv
// Sysclk-side OCI RAM controller: JTAG debug commands and CPU debug accesses share one RAM port.
module nios_dbg_ocimem_sequencer
    import nios_dbg_pkg::*;
#(
    parameter int unsigned AW           = 8,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [JDO_W-1:0] jdo,
    input  logic             take_action_ocimem_a,
    input  logic             take_no_action_ocimem_a,
    input  logic             take_action_ocimem_b,
    nios_dbg_ocimem_sequencer_if.slave cpu,
    output logic             ram_en,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_wdata,
    input  logic [DW-1:0]    ram_rdata,
    output logic [31:0]      MonDReg,
    output logic             monitor_ready,
    output logic             monitor_error
);

    state_t        state;
    cmd_t          pend_cmd;
    logic [AW-1:0] jaddr;
    logic [DW-1:0] pend_data;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;

    logic [1:0]    n_take;
    logic          take_any;
    logic          sel_a;
    logic          sel_b;
    logic          busy;
    logic          accept;
    logic          drop_err;
    cmd_t          cmd_in;
    cmd_t          new_cmd;
    cmd_t          exec_cmd;
    logic          jtag_req;
    logic          grant_jtag;
    logic          grant_cpu;
    logic          jdo_unused;

    assign jdo_unused = ^{jdo[JDO_W-1:JDO_RDEN+1], jdo[JDO_DATA_LSB-1:0]};

    // Decode take_* pulses; a new command may go straight to the arbiter in the same cycle.
    always_comb begin
        n_take   = {1'b0, take_action_ocimem_a} + {1'b0, take_no_action_ocimem_a}
                 + {1'b0, take_action_ocimem_b};
        take_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        sel_b    = take_action_ocimem_b;
        sel_a    = take_action_ocimem_a & ~take_action_ocimem_b;
        cmd_in   = CMD_NONE;
        if (sel_b) begin
            cmd_in = CMD_WR;
        end else if (sel_a) begin
            cmd_in = jdo[JDO_RDEN] ? CMD_RD : CMD_NONE;
        end else if (take_no_action_ocimem_a) begin
            cmd_in = CMD_RD;
        end
        busy     = (pend_cmd != CMD_NONE) || is_jtag_state(state);
        accept   = take_any & ~busy;
        drop_err = (n_take > 2'd1) || (take_any && busy);
        new_cmd  = accept ? cmd_in : CMD_NONE;
        jtag_req = (pend_cmd != CMD_NONE) || (new_cmd != CMD_NONE);
        exec_cmd = (pend_cmd != CMD_NONE) ? pend_cmd : new_cmd;
    end

    nios_dbg_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .arb_en     (state == IDLE),
        .jtag_req   (jtag_req),
        .cpu_req    (cpu.cpu_req),
        .grant_jtag (grant_jtag),
        .grant_cpu  (grant_cpu)
    );

    // State sequencing, command slot and all registered status/CPU outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            pend_cmd       <= CMD_NONE;
            jaddr          <= '0;
            pend_data      <= '0;
            c_addr         <= '0;
            c_wdata        <= '0;
            cpu.cpu_gnt    <= 1'b0;
            cpu.cpu_rvalid <= 1'b0;
            cpu.cpu_rdata  <= '0;
            MonDReg        <= '0;
            monitor_ready  <= 1'b1;
            monitor_error  <= 1'b0;
        end else begin
            cpu.cpu_gnt    <= 1'b0;
            cpu.cpu_rvalid <= 1'b0;

            if (accept && sel_a) begin
                jaddr <= jdo[JDO_ADDR_LSB +: AW];
            end
            if (accept && sel_b) begin
                pend_data <= jdo[JDO_DATA_LSB +: DW];
            end
            if (new_cmd != CMD_NONE) begin
                monitor_ready <= 1'b0;
            end
            if (drop_err) begin
                monitor_error <= 1'b1;
            end else if (accept && sel_b && jdo[JDO_RDEN]) begin
                monitor_error <= 1'b0;
            end
            if (grant_jtag) begin
                pend_cmd <= CMD_NONE;
            end else if (new_cmd != CMD_NONE) begin
                pend_cmd <= new_cmd;
            end

            case (state)
                IDLE: begin
                    if (grant_jtag) begin
                        state <= (exec_cmd == CMD_WR) ? J_WR : J_RD;
                    end else if (grant_cpu) begin
                        state       <= cpu.cpu_we ? C_WR : C_RD;
                        c_addr      <= cpu.cpu_addr;
                        c_wdata     <= cpu.cpu_wdata;
                        cpu.cpu_gnt <= 1'b1;
                    end
                end
                J_RD: state <= J_RCAP;
                J_RCAP: begin
                    MonDReg       <= 32'(ram_rdata);
                    jaddr         <= jaddr + AW'(1);
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                J_WR: begin
                    jaddr         <= jaddr + AW'(1);
                    monitor_ready <= 1'b1;
                    state         <= IDLE;
                end
                C_RD: state <= C_RCAP;
                C_RCAP: begin
                    cpu.cpu_rdata  <= ram_rdata;
                    cpu.cpu_rvalid <= 1'b1;
                    state          <= IDLE;
                end
                C_WR:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM port strobes decoded from the current state.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = jaddr;
        ram_wdata = pend_data;
        case (state)
            J_RD: ram_en = 1'b1;
            J_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
            end
            C_RD: begin
                ram_en   = 1'b1;
                ram_addr = c_addr;
            end
            C_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = c_addr;
                ram_wdata = c_wdata;
            end
            default: ;
        endcase
    end

endmodule
